two_of_five_scan_display: RTL and testbench



---
 rtl/two_of_five_pkg.sv | 26 ++
 rtl/two_of_five_seg_decoder.sv | 20 ++
 rtl/two_of_five_scan_display.sv | 95 +++++++++
 tb/tb_two_of_five_scan_display.sv | 124 ++++++++++++
 4 files changed

// File: rtl/two_of_five_pkg.sv
// two_of_five_pkg: 2-of-5 code type, digit code table and 7-segment patterns {g,f,e,d,c,b,a}
package two_of_five_pkg;
   typedef logic [4:0] code_t;
   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;
   // entry i is the code of decimal digit i (weights 7,4,2,1,0)
   localparam logic [9:0][4:0] CODE_TABLE = {
      5'b10100, 5'b10010, 5'b10001, 5'b01100, 5'b01010,
      5'b01001, 5'b00110, 5'b00101, 5'b00011, 5'b11000};
   localparam logic [9:0][6:0] SEG_TABLE = {
      SEG_9, SEG_8, SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
   function automatic logic code_valid(code_t c);
      code_valid = 1'b0;
      for (int i = 0; i < 10; i++) code_valid = code_valid | (c == CODE_TABLE[i]);
   endfunction
endpackage

// File: rtl/two_of_five_seg_decoder.sv
// two_of_five_seg_decoder: 2-of-5 code to active-high segment pattern; invalid codes give SEG_OFF, valid=0
module two_of_five_seg_decoder
   import two_of_five_pkg::*;
(
   input  code_t      code,
   output logic [6:0] pattern,
   output logic       valid
);
   // table lookup over the ten legal codes
   always_comb begin
      pattern = SEG_OFF;
      valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (code == CODE_TABLE[i]) begin
            pattern = SEG_TABLE[i];
            valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/two_of_five_scan_display.sv
// two_of_five_scan_display: multiplexed N-digit 2-of-5 display scanner; TWO_OF_FIVE_ERR_BLINK_EN adds error-digit blinking
module two_of_five_scan_display
   import two_of_five_pkg::*;
#(
   parameter int DIGITS         = 4,
   parameter int PRESCALE       = 50000,
   parameter int BLANK_CYCLES   = 2,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int DIG_ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  load,
   input  logic [5*DIGITS-1:0]   code_in,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [DIGITS-1:0]     err
);
   localparam int PW = $clog2(PRESCALE);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam logic [6:0] SEG_IDLE = SEG_ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
   localparam logic [DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW != 0 ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   if (DIGITS < 1 || DIGITS > 8 || PRESCALE < 2 || BLANK_CYCLES < 0 || BLANK_CYCLES >= PRESCALE) begin : g_bad_param
      $error("two_of_five_scan_display: parameter out of range");
   end

   code_t [DIGITS-1:0] shadow_q, shadow_d;
   logic [PW-1:0]      pcnt_q, pcnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [DIGITS-1:0]  err_q, err_d, dig_q, dig_d;
   logic [6:0]         seg_q, seg_d, pat;
   logic               cur_ok, tick, last;
`ifdef TWO_OF_FIVE_ERR_BLINK_EN
   logic [3:0]         frame_q, frame_d;
   logic               blink_q, blink_d;
`endif

   two_of_five_seg_decoder u_dec (.code(shadow_q[idx_q]), .pattern(pat), .valid(cur_ok));

   // next-state: capture, scan counters, error flags and polarity-adjusted outputs
   always_comb begin
      tick = pcnt_q == PW'(PRESCALE - 1);
      last = idx_q == IW'(DIGITS - 1);
      shadow_d = load ? code_in : shadow_q;
      pcnt_d = (!enable || tick) ? '0 : pcnt_q + 1'b1;
      idx_d = (!enable || (tick && last)) ? '0 : tick ? idx_q + 1'b1 : idx_q;
      for (int k = 0; k < DIGITS; k++) err_d[k] = !code_valid(shadow_q[k]);
`ifdef TWO_OF_FIVE_ERR_BLINK_EN
      frame_d = !enable ? 4'd0 : (tick && last) ? frame_q + 4'd1 : frame_q;
      blink_d = !enable ? 1'b0 : (tick && last && frame_q == 4'hf) ? !blink_q : blink_q;
      seg_d = (!enable ? SEG_OFF : cur_ok ? pat : blink_q ? SEG_OFF : SEG_DASH) ^ SEG_IDLE;
`else
      seg_d = (!enable ? SEG_OFF : cur_ok ? pat : SEG_DASH) ^ SEG_IDLE;
`endif
      dig_d = ((enable && pcnt_q >= PW'(BLANK_CYCLES)) ? DIGITS'(1) << idx_q : '0) ^ DIG_IDLE;
   end

   // state and registered outputs; reset shows all-zero digits with the display dark
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q <= {DIGITS{5'b11000}};
         pcnt_q <= '0;
         idx_q <= '0;
         err_q <= '0;
         seg_q <= SEG_IDLE;
         dig_q <= DIG_IDLE;
      end else begin
         shadow_q <= shadow_d;
         pcnt_q <= pcnt_d;
         idx_q <= idx_d;
         err_q <= err_d;
         seg_q <= seg_d;
         dig_q <= dig_d;
      end
   end

`ifdef TWO_OF_FIVE_ERR_BLINK_EN
   // frame counter toggling the blink phase every 16 complete frames
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_q <= 4'd0;
         blink_q <= 1'b0;
      end else begin
         frame_q <= frame_d;
         blink_q <= blink_d;
      end
   end
`endif

   assign seg = seg_q;
   assign dig_sel = dig_q;
   assign err = err_q;
endmodule

// File: tb/tb_two_of_five_scan_display.sv
// tb_two_of_five_scan_display: table-driven check of scan, capture, blanking, enable and reset behaviour
module tb_two_of_five_scan_display;
   typedef struct {
      logic        en;
      logic        ld;
      logic [19:0] code;
      logic [6:0]  seg;
      logic [3:0]  dig;
      logic [3:0]  err;
   } vec_t;

   localparam logic [6:0] Z   = 7'h40;
   localparam logic [6:0] S1  = 7'h79;
   localparam logic [6:0] S3  = 7'h30;
   localparam logic [6:0] S5  = 7'h12;
   localparam logic [6:0] S6  = 7'h02;
   localparam logic [6:0] S9  = 7'h10;
   localparam logic [6:0] SD  = 7'h3f;
   localparam logic [6:0] OFF = 7'h7f;
   localparam logic [19:0] C1 = 20'b10100_01010_00110_00011;
   localparam logic [19:0] C2 = 20'b10100_00111_00110_00011;
   localparam logic [19:0] C3 = 20'b10100_01100_00110_00011;

   logic        clk, reset, enable, load;
   logic [19:0] code_in;
   logic [6:0]  seg;
   logic [3:0]  dig_sel, err;
   vec_t        vq[$];
   int          passed, total;

   two_of_five_scan_display #(.DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .code_in(code_in), .seg(seg), .dig_sel(dig_sel), .err(err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic en, input logic ld, input logic [19:0] code,
                      input logic [6:0] s, input logic [3:0] d, input logic [3:0] e, input int n);
      vec_t v;
      v.en = en; v.ld = ld; v.code = code; v.seg = s; v.dig = d; v.err = e;
      for (int i = 0; i < n; i++) vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s step %0d: got %h expected %h", nm, i, act, exp);
   endtask

   task automatic chk_all(input string tag, input int i, input logic [6:0] s, input logic [3:0] d, input logic [3:0] e);
      chk({tag, " seg"}, i, 32'(seg), 32'(s));
      chk({tag, " dig_sel"}, i, 32'(dig_sel), 32'(d));
      chk({tag, " err"}, i, 32'(err), 32'(e));
   endtask

   initial begin
      passed = 0;
      total = 0;
      add(1, 0, 0,  Z,  4'hf, 4'h0, 1);
      add(1, 0, 0,  Z,  4'he, 4'h0, 3);
      add(1, 0, 0,  Z,  4'hf, 4'h0, 1);
      add(1, 0, 0,  Z,  4'hd, 4'h0, 3);
      add(1, 0, 0,  Z,  4'hf, 4'h0, 1);
      add(1, 0, 0,  Z,  4'hb, 4'h0, 3);
      add(1, 0, 0,  Z,  4'hf, 4'h0, 1);
      add(1, 0, 0,  Z,  4'h7, 4'h0, 3);
      add(1, 1, C1, Z,  4'hf, 4'h0, 1);
      add(1, 0, 0,  S1, 4'he, 4'h0, 3);
      add(1, 0, 0,  S3, 4'hf, 4'h0, 1);
      add(1, 0, 0,  S3, 4'hd, 4'h0, 3);
      add(1, 0, 0,  S5, 4'hf, 4'h0, 1);
      add(1, 0, 0,  S5, 4'hb, 4'h0, 3);
      add(1, 0, 0,  S9, 4'hf, 4'h0, 1);
      add(1, 0, 0,  S9, 4'h7, 4'h0, 3);
      add(1, 1, C2, S1, 4'hf, 4'h0, 1);
      add(1, 0, 0,  S1, 4'he, 4'h4, 3);
      add(1, 0, 0,  S3, 4'hf, 4'h4, 1);
      add(1, 0, 0,  S3, 4'hd, 4'h4, 3);
      add(1, 0, 0,  SD, 4'hf, 4'h4, 1);
      add(1, 0, 0,  SD, 4'hb, 4'h4, 1);
      add(0, 0, 0,  OFF, 4'hf, 4'h4, 2);
      add(1, 0, 0,  S1, 4'hf, 4'h4, 1);
      add(1, 0, 0,  S1, 4'he, 4'h4, 3);
      add(1, 0, 0,  S3, 4'hf, 4'h4, 1);
      add(1, 0, 0,  S3, 4'hd, 4'h4, 2);
      add(1, 1, C3, S3, 4'hd, 4'h4, 1);
      add(1, 0, 0,  S6, 4'hf, 4'h0, 1);
      add(1, 0, 0,  S6, 4'hb, 4'h0, 2);

      reset = 1'b1;
      enable = 1'b1;
      load = 1'b0;
      code_in = '0;
      #2;
      chk_all("async reset", 0, OFF, 4'hf, 4'h0);
      @(posedge clk);
      #1;
      chk_all("reset held", 0, OFF, 4'hf, 4'h0);
      reset = 1'b0;

      foreach (vq[i]) begin
         enable = vq[i].en;
         load = vq[i].ld;
         code_in = vq[i].code;
         @(posedge clk);
         #1;
         chk_all("scan", i, vq[i].seg, vq[i].dig, vq[i].err);
      end
      load = 1'b0;
      code_in = '0;

      #2 reset = 1'b1;
      #1 chk_all("mid-scan reset", 0, OFF, 4'hf, 4'h0);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 chk_all("after reset", 0, Z, 4'hf, 4'h0);
      @(posedge clk);
      #1 chk_all("after reset", 1, Z, 4'he, 4'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
